// File: rtl/water_pump_ctrl.sv
// Tank pump controller: synchronises and debounces the 2-bit level sensor, runs the
// fill FSM with hysteresis, latches sensor/timeout faults until acked, drives the status letter.
module water_pump_ctrl #(
  parameter int DEBOUNCE = 4,
  parameter int MAX_FILL = 16
) (
  input  logic       clk_2,
  input  logic       reset_n,
  input  logic [1:0] sensor,
  input  logic       ack,
  output logic [7:0] seg,
  output logic       pump,
  output logic       alarm,
  output logic [1:0] state_o,
  output logic [7:0] fill_count
);
  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, FAULT = 2'd2} state_t;

  localparam logic [1:0] LVL_HIGH = 2'b00;
  localparam logic [1:0] LVL_NORM = 2'b01;
  localparam logic [1:0] LVL_LOW  = 2'b10;
  localparam logic [1:0] LVL_DEF  = 2'b11;
  localparam logic [3:0] DB_N     = 4'(DEBOUNCE);
  localparam logic [7:0] TMO_LAST = 8'(MAX_FILL - 1);

  logic [1:0] sync1, samp, level, cand;
  logic [1:0] level_nxt, cand_nxt;
  logic [3:0] db_cnt, cnt_nxt, cnt_inc;
  state_t     state, state_nxt;
  logic [7:0] timer, timer_nxt, fc_nxt;
  logic       tmo, tmo_nxt;
  logic [7:0] seg_nxt;
  logic       pump_nxt, alarm_nxt;

  // Debounce: a first differing sample counts as 1, so DEBOUNCE=1 accepts immediately.
  always_comb begin
    level_nxt = level;
    cand_nxt  = cand;
    cnt_nxt   = db_cnt;
    cnt_inc   = (samp != cand) ? 4'd1 : db_cnt + 4'd1;
    if (samp == level) begin
      cnt_nxt = '0;
    end else begin
      cand_nxt = samp;
      if (cnt_inc == DB_N) begin
        level_nxt = samp;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = cnt_inc;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    tmo_nxt   = tmo;
    fc_nxt    = fill_count;
    case (state)
      IDLE: begin
        if (level == LVL_DEF) begin
          state_nxt = FAULT;
          tmo_nxt   = 1'b0;
        end else if (level == LVL_LOW) begin
          state_nxt = FILL;
          timer_nxt = '0;
        end
      end
      FILL: begin
        // High level outranks the timeout so a fill finishing on the last cycle counts.
        if (level == LVL_DEF) begin
          state_nxt = FAULT;
          tmo_nxt   = 1'b0;
        end else if (level == LVL_HIGH) begin
          state_nxt = IDLE;
          fc_nxt    = (fill_count == 8'hff) ? fill_count : fill_count + 8'd1;
        end else if (timer == TMO_LAST) begin
          state_nxt = FAULT;
          tmo_nxt   = 1'b1;
        end else begin
          timer_nxt = timer + 8'd1;
        end
      end
      FAULT: begin
        if (ack && level != LVL_DEF) begin
          state_nxt = IDLE;
          tmo_nxt   = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they move with the state/level registers.
  always_comb begin
    pump_nxt  = (state_nxt == FILL);
    alarm_nxt = (state_nxt == FAULT);
    seg_nxt   = 8'h54;
    if (state_nxt == FAULT) begin
      seg_nxt = tmo_nxt ? 8'h78 : 8'h5e;
    end else begin
      case (level_nxt)
        LVL_HIGH: seg_nxt = 8'h5f;
        LVL_NORM: seg_nxt = 8'h54;
        LVL_LOW:  seg_nxt = 8'h7c;
        default:  seg_nxt = 8'h5e;
      endcase
    end
  end

  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      sync1      <= LVL_NORM;
      samp       <= LVL_NORM;
      level      <= LVL_NORM;
      cand       <= LVL_NORM;
      db_cnt     <= '0;
      state      <= IDLE;
      timer      <= '0;
      tmo        <= 1'b0;
      fill_count <= '0;
      pump       <= 1'b0;
      alarm      <= 1'b0;
      seg        <= 8'h54;
    end else begin
      sync1      <= sensor;
      samp       <= sync1;
      level      <= level_nxt;
      cand       <= cand_nxt;
      db_cnt     <= cnt_nxt;
      state      <= state_nxt;
      timer      <= timer_nxt;
      tmo        <= tmo_nxt;
      fill_count <= fc_nxt;
      pump       <= pump_nxt;
      alarm      <= alarm_nxt;
      seg        <= seg_nxt;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_water_pump_ctrl.sv
// Scoreboard bench for water_pump_ctrl: stimulus queues cycle-stamped output snapshots,
// the monitor checks each when due and flags any output change nobody predicted.
`timescale 1ns/1ps
module tb_water_pump_ctrl;
  logic       clk_2   = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] sensor  = 2'b01;
  logic       ack     = 1'b0;
  logic [7:0] seg, fill_count;
  logic       pump, alarm;
  logic [1:0] state_o;

  water_pump_ctrl #(.DEBOUNCE(4), .MAX_FILL(16)) dut (
    .clk_2(clk_2), .reset_n(reset_n), .sensor(sensor), .ack(ack),
    .seg(seg), .pump(pump), .alarm(alarm), .state_o(state_o), .fill_count(fill_count)
  );

  always #5 clk_2 = ~clk_2;

  typedef struct {
    int         cyc;
    string      tag;
    logic [7:0] seg;
    logic       pump;
    logic       alarm;
    logic [1:0] st;
    logic [7:0] fc;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  int   base   = 0;
  int   fcx    = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk_2) cyc <= cyc + 1;

  task automatic expect_at(input int dc, input string tag, input logic [7:0] s,
                           input logic p, input logic a, input logic [1:0] st, input logic [7:0] fc);
    exp_t e;
    e.cyc = base + dc; e.tag = tag; e.seg = s; e.pump = p; e.alarm = a; e.st = st; e.fc = fc;
    q.push_back(e);
  endtask

  task automatic drive(input logic [1:0] s);
    sensor = s;
    base   = cyc;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_2);
  endtask

  // Monitor: samples 1ns after each rising edge
  initial begin
    logic [19:0] prev, cur;
    exp_t e;
    prev = '0;
    forever begin
      @(posedge clk_2); #1;
      cur = {seg, pump, alarm, state_o, fill_count};
      if (mon_en) begin
        if (q.size() > 0 && q[0].cyc <= cyc) begin
          e = q.pop_front();
          checks++;
          if (e.cyc != cyc || cur !== {e.seg, e.pump, e.alarm, e.st, e.fc}) begin
            errors++;
            $display("FAIL %s @cyc %0d: got seg=%h pump=%b alarm=%b st=%0d fc=%0d, want seg=%h pump=%b alarm=%b st=%0d fc=%0d at cyc %0d",
                     e.tag, cyc, seg, pump, alarm, state_o, fill_count,
                     e.seg, e.pump, e.alarm, e.st, e.fc, e.cyc);
          end
        end else if (cur !== prev) begin
          checks++;
          errors++;
          $display("FAIL unexpected_change @cyc %0d: got seg=%h pump=%b alarm=%b st=%0d fc=%0d, want no change",
                   cyc, seg, pump, alarm, state_o, fill_count);
        end
      end
      prev = cur;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset, hold normal level
    step(3);
    reset_n = 1'b1;
    base    = cyc;
    mon_en  = 1'b1;
    for (int i = 1; i <= 8; i++) expect_at(i, "reset_idle", 8'h54, 0, 0, 2'd0, 8'd0);
    step(8);

    // 2: normal fill cycle
    drive(2'b10);
    expect_at(6, "fill_seg_low", 8'h7c, 0, 0, 2'd0, 8'd0);
    expect_at(7, "fill_pump_on", 8'h7c, 1, 0, 2'd1, 8'd0);
    step(10);
    drive(2'b00);
    expect_at(6, "fill_seg_high", 8'h5f, 1, 0, 2'd1, 8'd0);
    expect_at(7, "fill_done", 8'h5f, 0, 0, 2'd0, 8'd1);
    fcx = 1;
    step(10);

    // 3: glitch rejection
    drive(2'b01);
    expect_at(6, "back_to_normal", 8'h54, 0, 0, 2'd0, 8'(fcx));
    step(8);
    drive(2'b10);
    for (int i = 1; i <= 12; i++) expect_at(i, "glitch_ignored", 8'h54, 0, 0, 2'd0, 8'(fcx));
    step(3);
    sensor = 2'b01;
    step(10);

    // 4: fill timeout and acknowledge
    drive(2'b10);
    expect_at(6,  "tmo_seg_low", 8'h7c, 0, 0, 2'd0, 8'(fcx));
    expect_at(7,  "tmo_pump_on", 8'h7c, 1, 0, 2'd1, 8'(fcx));
    expect_at(22, "tmo_last_fill", 8'h7c, 1, 0, 2'd1, 8'(fcx));
    expect_at(23, "tmo_fault", 8'h78, 0, 1, 2'd2, 8'(fcx));
    step(25);
    drive(2'b01);
    expect_at(6, "tmo_hold_no_ack", 8'h78, 0, 1, 2'd2, 8'(fcx));
    expect_at(8, "tmo_hold_no_ack2", 8'h78, 0, 1, 2'd2, 8'(fcx));
    step(8);
    ack  = 1'b1;
    base = cyc;
    expect_at(1, "tmo_ack_idle", 8'h54, 0, 0, 2'd0, 8'(fcx));
    step(1);
    ack = 1'b0;
    step(3);

    // 5: sensor defect during fill
    drive(2'b10);
    expect_at(6, "def_seg_low", 8'h7c, 0, 0, 2'd0, 8'(fcx));
    expect_at(7, "def_pump_on", 8'h7c, 1, 0, 2'd1, 8'(fcx));
    step(8);
    drive(2'b11);
    expect_at(6, "def_seg_d", 8'h5e, 1, 0, 2'd1, 8'(fcx));
    expect_at(7, "def_fault", 8'h5e, 0, 1, 2'd2, 8'(fcx));
    step(9);
    ack  = 1'b1;
    base = cyc;
    expect_at(1, "def_ack_ignored", 8'h5e, 0, 1, 2'd2, 8'(fcx));
    expect_at(3, "def_ack_ignored2", 8'h5e, 0, 1, 2'd2, 8'(fcx));
    step(3);
    ack = 1'b0;
    drive(2'b01);
    expect_at(6, "def_level_ok_still_fault", 8'h5e, 0, 1, 2'd2, 8'(fcx));
    step(6);
    ack  = 1'b1;
    base = cyc;
    expect_at(1, "def_ack_idle", 8'h54, 0, 0, 2'd0, 8'(fcx));
    step(1);
    ack = 1'b0;
    step(2);

    // 6a: 256 fill cycles, count saturates at 255
    for (int i = 0; i < 256; i++) begin
      drive(2'b10);
      expect_at(6, "sat_seg_low", 8'h7c, 0, 0, 2'd0, 8'(fcx));
      expect_at(7, "sat_pump_on", 8'h7c, 1, 0, 2'd1, 8'(fcx));
      step(10);
      drive(2'b00);
      expect_at(6, "sat_seg_high", 8'h5f, 1, 0, 2'd1, 8'(fcx));
      fcx = (fcx == 255) ? 255 : fcx + 1;
      expect_at(7, "sat_count", 8'h5f, 0, 0, 2'd0, 8'(fcx));
      step(10);
    end

    // 6b: high level lands on the same edge as the timeout -> high wins
    drive(2'b10);
    expect_at(6,  "tie_seg_low", 8'h7c, 0, 0, 2'd0, 8'd255);
    expect_at(7,  "tie_pump_on", 8'h7c, 1, 0, 2'd1, 8'd255);
    expect_at(22, "tie_level_high", 8'h5f, 1, 0, 2'd1, 8'd255);
    expect_at(23, "tie_idle_no_alarm", 8'h5f, 0, 0, 2'd0, 8'd255);
    expect_at(25, "tie_stays_idle", 8'h5f, 0, 0, 2'd0, 8'd255);
    step(16);
    sensor = 2'b00;
    step(10);

    // 6c: asynchronous reset mid-fill
    drive(2'b10);
    expect_at(6,  "rst_seg_low", 8'h7c, 0, 0, 2'd0, 8'd255);
    expect_at(7,  "rst_pump_on", 8'h7c, 1, 0, 2'd1, 8'd255);
    expect_at(10, "rst_still_fill", 8'h7c, 1, 0, 2'd1, 8'd255);
    step(10);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d unchecked snapshots, want 0", q.size());
    end
    #2;
    mon_en  = 1'b0;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({pump, alarm, state_o, fill_count, seg} !== {1'b0, 1'b0, 2'd0, 8'd0, 8'h54}) begin
      errors++;
      $display("FAIL async_reset: got pump=%b alarm=%b st=%0d fc=%0d seg=%h, want pump=0 alarm=0 st=0 fc=0 seg=54",
               pump, alarm, state_o, fill_count, seg);
    end
    step(2);
    reset_n = 1'b1;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/water_pump_ctrl.md
Name: water_pump_ctrl

Overview:
- FSM controller for the tank pump, driven by the 2-bit water-level sensor that the board switches emulate.
- Synchronises and debounces the sensor code, then sequences the pump with hysteresis: it starts on low level and stops on high level.
- Detects a sensor fault or a fill timeout, latches an alarm until it is acknowledged, and drives the 7-segment status letter.
- Sits between the switch inputs and the LED/SEG outputs of top.

Parameters:
- DEBOUNCE, 4, consecutive identical synchronised samples required before a new level is accepted (range 1..15).
- MAX_FILL, 16, maximum cycles allowed in FILL before a timeout fault (range 2..255).

Ports:
- clk_2  input  1  system clock (divided board clock).
- reset_n  input  1  asynchronous, active-low reset.
- sensor  input  2  raw level code: 00 high, 01 normal, 10 low, 11 sensor defect.
- ack  input  1  alarm acknowledge, level-sensitive, sampled on clk_2.
- seg  output  8  7-segment pattern for the status letter.
- pump  output  1  1 = pump running.
- alarm  output  1  1 = fault latched.
- state_o  output  2  FSM state: 0 IDLE, 1 FILL, 2 FAULT (3 unused).
- fill_count  output  8  completed fill cycles, saturating.

Behaviour:
- Reset (reset_n=0, asynchronous), all registered:
  - both sync flops = 01; stable level = 01; debounce candidate = 01; debounce count = 0.
  - state IDLE, fill timer = 0, timeout flag = 0.
  - pump = 0, alarm = 0, fill_count = 0, seg = 0x54.
- Synchroniser: sensor passes through two flops; "samp" is the second flop.
- Debounce, evaluated each edge:
  - samp == level: count cleared.
  - samp != level and samp != cand: cand <= samp, count <= 1.
  - samp != level and samp == cand: count increments; when the incremented count equals DEBOUNCE, level <= cand and count <= 0.
  - DEBOUNCE=1: a differing samp is accepted on the same edge it is first seen.
  - Net latency: a sensor change held constant appears on level exactly 2+DEBOUNCE edges later. Glitches shorter than DEBOUNCE samples never reach level.
- FSM, evaluated on the registered level. Within a state the rules are listed in priority order.
  - IDLE:
    - level==11 -> FAULT with timeout flag = 0.
    - level==10 -> FILL, timer <= 0.
    - otherwise stay. Normal or high keeps the pump off (hysteresis).
  - FILL:
    - level==11 -> FAULT with timeout flag = 0.
    - level==00 -> IDLE, fill_count += 1, saturating at 255.
    - timer == MAX_FILL-1 -> FAULT with timeout flag = 1.
    - otherwise timer += 1.
    - If high level and timeout occur on the same edge, high wins: the FSM goes to IDLE, the count increments and no fault is raised.
  - FAULT:
    - ack==1 and level!=11 -> IDLE, timeout flag cleared.
    - otherwise stay. An ack while level==11 is ignored.
    - A FAULT entered from a timeout is not cleared by the level changing; ack is required.
- Outputs: Moore, registered, and updated on the same edge as the state register.
  - pump = (state==FILL).
  - alarm = (state==FAULT).
  - state_o = state encoding.
  - seg in IDLE/FILL, from level:
    - 00 -> 0x5f "a".
    - 01 -> 0x54 "n".
    - 10 -> 0x7c "b".
    - 11 -> 0x5e "d".
  - seg in FAULT: 0x78 "t" if the timeout flag is set, else 0x5e.
- Latency: the pump reacts 3+DEBOUNCE edges after a held sensor change.
- Reset mid-FILL: the pump drops immediately (asynchronously) and fill_count is lost.
- fill_count stays at 255 once saturated.

Test Plan (DEBOUNCE=4, MAX_FILL=16 unless stated):
1. Reset, then hold sensor=01 -> seg=0x54, pump=0, state_o=0, alarm=0 throughout.
2. Normal fill cycle:
   - Drive sensor=10 -> seg=0x7c after 6 edges; pump=1 and state_o=1 on the 7th.
   - Then drive sensor=00 within 10 cycles -> pump=0, state_o=0, fill_count=1, seg=0x5f.
3. Glitch rejection: in IDLE, pulse sensor=10 for 3 cycles, then 01 -> level, seg and pump unchanged.
4. Fill timeout and acknowledge:
   - Enter FILL and hold sensor=10 -> after 16 cycles in FILL, state_o=2, alarm=1, pump=0, seg=0x78.
   - Drive sensor=01 with ack=0 -> stays FAULT.
   - Assert ack=1 -> IDLE next edge, alarm=0, seg=0x54.
5. Sensor defect:
   - During FILL, drive sensor=11 -> FAULT with seg=0x5e after 7 edges.
   - ack=1 while sensor=11 -> still FAULT.
   - Drive sensor=01, wait 6 edges, ack=1 -> IDLE.
6. Saturation, tie and reset:
   - Run 256 fill cycles -> fill_count=255.
   - Set level to 00 on the edge where the timer reaches 15 -> IDLE, no alarm.
   - Pull reset_n low mid-FILL -> pump=0 and fill_count=0 immediately, without a clock edge.
